bcd_display_scanner: RTL

- Downstream consumer of the three-digit BCD counter outputs (digit_001/digit_010/digit_100).
- Snapshots the digits and time-multiplexes them onto one common-anode 7-segment bus with per-digit enables.
- Provides a guard (blanking) interval at every digit change to suppress ghosting.
- Flags non-BCD input codes.

---
 rtl/bcd_disp_pkg.sv | 41 ++++
 rtl/bcd_to_7seg.sv | 14 +
 rtl/bcd_display_scanner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types, constants and the BCD -> 7-segment decode for the display
// scanner.
//   bcd_t        one BCD digit
//   seg_t        active-low segment vector, [0]=a ... [6]=g
//   SEG_OFF      all segments dark
//   SEG_DASH     only segment g lit, used for codes 10..15
//   bcd_to_seg   single-digit decode, non-BCD codes map to SEG_DASH
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam int   NUM_DIGITS = 3;
  localparam seg_t SEG_OFF    = 7'h7F;
  localparam seg_t SEG_DASH   = 7'b0111111;

  typedef enum logic {
    GUARD_ST = 1'b0,
    DRIVE_ST = 1'b1
  } scan_state_t;

  // Active-low, bit order g..a.
  function automatic seg_t bcd_to_seg(input bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational single-digit BCD to active-low 7-segment decoder.
// Ports:
//   i_bcd  [3:0]  digit to decode
//   o_seg  [6:0]  active-low segments, [0]=a ... [6]=g (dash for 10..15)
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/bcd_display_scanner.sv
// Snapshots three BCD digits and time-multiplexes them onto a single
// common-anode 7-segment bus. Each digit slot lasts SCAN_DIV clocks; the
// first GUARD clocks of every slot keep all enables off to avoid ghosting.
// Any snapshot digit above 9 is shown as a dash and sets a sticky flag.
//
// Parameters:
//   SCAN_DIV  clocks per digit slot (4 .. 2**20)
//   GUARD     blanking clocks at the start of each slot (1 <= GUARD < SCAN_DIV)
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous reset, active-low
//   digit_001  units digit      digit_010  tens digit    digit_100  hundreds digit
//   latch_en   load the three digits into the snapshot on this edge
//   seg_n      segments, active-low, [0]=a ... [6]=g
//   dig_sel_n  digit enables, active-low, [0]=units [1]=tens [2]=hundreds
//   bad_code   sticky, a snapshot digit was > 9
// Build option:
//   BCD_DISPLAY_LZ_BLANK_EN  blank leading zeros in the hundreds/tens slots
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit_001,
  input  logic [3:0] digit_010,
  input  logic [3:0] digit_100,
  input  logic       latch_en,
  output logic [6:0] seg_n,
  output logic [2:0] dig_sel_n,
  output logic       bad_code
);

  localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD);

  bcd_t [NUM_DIGITS-1:0] r_snap;
  logic [PW-1:0]         r_presc;
  logic [PW-1:0]         w_presc_nxt;
  logic [1:0]            r_idx;
  logic [1:0]            w_idx_nxt;
  scan_state_t           r_state;
  scan_state_t           w_state_nxt;
  seg_t                  r_seg;
  seg_t                  w_seg_nxt;
  logic [2:0]            r_sel;
  logic [2:0]            w_sel_nxt;
  logic                  r_bad;
  logic [NUM_DIGITS-1:0] w_digit_bad;
  bcd_t                  w_cur_digit;
  seg_t                  w_dec_seg;
  logic                  w_blank;

  // Prescaler and slot index. The index wraps 2 -> 0 so it never shows 3.
  always_comb begin
    w_presc_nxt = r_presc + 1'b1;
    w_idx_nxt   = r_idx;
    if (r_presc == PRE_TC) begin
      w_presc_nxt = '0;
      w_idx_nxt   = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end
  end

  // Digit mux ahead of the single shared decoder.
  always_comb begin
    case (r_idx)
      2'd1:    w_cur_digit = r_snap[1];
      2'd2:    w_cur_digit = r_snap[2];
      default: w_cur_digit = r_snap[0];
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_cur_digit),
    .o_seg (w_dec_seg)
  );

`ifdef BCD_DISPLAY_LZ_BLANK_EN
  // Leading-zero blanking: hundreds blank on 0, tens blank only when the
  // hundreds digit is also 0. Units always show.
  always_comb begin
    w_blank = 1'b0;
    if (r_idx == 2'd2 && r_snap[2] == 4'd0)
      w_blank = 1'b1;
    if (r_idx == 2'd1 && r_snap[1] == 4'd0 && r_snap[2] == 4'd0)
      w_blank = 1'b1;
  end
`else
  assign w_blank = 1'b0;
`endif

  // r_state always describes the current prescaler value, so the next
  // state is derived from the next prescaler value. Outputs are registered
  // from the current state/index, giving one cycle of pin latency.
  always_comb begin
    w_state_nxt = (w_presc_nxt < PRE_GUARD) ? GUARD_ST : DRIVE_ST;
    w_sel_nxt   = 3'b111;
    w_seg_nxt   = SEG_OFF;
    case (r_state)
      DRIVE_ST: begin
        w_sel_nxt = ~(3'b001 << r_idx);
        w_seg_nxt = w_blank ? SEG_OFF : w_dec_seg;
      end
      default: ;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_bad
      assign w_digit_bad[g] = (r_snap[g] > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= GUARD_ST;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_snap  <= '0;
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_seg   <= SEG_OFF;
      r_sel   <= 3'b111;
      r_bad   <= 1'b0;
    end else begin
      if (latch_en)
        r_snap <= {digit_100, digit_010, digit_001};
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
      r_seg   <= w_seg_nxt;
      r_sel   <= w_sel_nxt;
      // Checks the snapshot as it stands, so a bad code flags one edge
      // after it is latched.
      r_bad   <= r_bad | (|w_digit_bad);
    end
  end

  assign seg_n     = r_seg;
  assign dig_sel_n = r_sel;
  assign bad_code  = r_bad;

endmodule
